mem_bist: RTL and testbench
===========================

# mem_bist

Built-in self-test master for the single-clock dual-port `ram` block (one write port, one registered read port). On `start` it drives the RAM's write port to fill every address with a seed-derived pattern. It then sweeps the read port and compares each returned word against the expected value. It sits beside the RAM as the initiator of its port signals and reports `pass`, an error count and the first failing address.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 3, RAM address width; depth N = 2**ADDR_WIDTH

Ports:
- `clk`  input  1  clock; all state updates on posedge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  begin a test run; sampled only in IDLE or DONE
- `seed`  input  DATA_WIDTH  pattern seed; captured on accepted `start`
- `busy`  output  1  high while a run is in progress
- `done`  output  1  high (level) in DONE until the next accepted `start` or reset
- `pass`  output  1  high in DONE when `err_count` == 0; otherwise 0
- `err_count`  output  ADDR_WIDTH+2  mismatch count, saturating at all-ones
- `first_err_addr`  output  ADDR_WIDTH  address of the first mismatch; 0 if none
- `ram_data`  output  DATA_WIDTH  to RAM `data`
- `ram_write_addr`  output  ADDR_WIDTH  to RAM `write_addr`
- `ram_read_addr`  output  ADDR_WIDTH  to RAM `read_addr`
- `ram_we`  output  1  to RAM `we`
- `ram_q`  input  DATA_WIDTH  from RAM `q`; valid the cycle after `ram_read_addr` is presented

## Operation
- Pattern: `pat(a) = seed_r + a`, modulo 2**DATA_WIDTH. `a` is zero-extended to, or truncated to, DATA_WIDTH.
- States: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE/DONE -> WRITE when `start` = 1. On entry: capture `seed`, clear `err_count`, `first_err_addr` and the first-error flag, and set `done` = 0.
  - WRITE: for a = 0..N-1, assert `ram_we` = 1 with `ram_write_addr` = a and `ram_data` = pat(a). After a = N-1, go to READ.
  - READ: for a = 0..N-1, drive `ram_read_addr` = a with `ram_we` = 0. After a = N-1, go to DRAIN.
  - DRAIN: one cycle that allows the final read data to be compared. Then go to DONE.
- Compare pipeline:
  - A one-cycle delayed valid flag and address (`cmp_v`, `cmp_a`) follow each read issue.
  - When `cmp_v` = 1, compare `ram_q` against pat(`cmp_a`).
  - On mismatch, increment `err_count` (saturating). If this is the first mismatch, latch `cmp_a` into `first_err_addr`.
- All RAM-side outputs come from registers. There is no combinational path from `start`, `seed` or `ram_q` to any output.
- `start` is ignored while `busy` = 1.
- When not in WRITE: `ram_we` = 0, and `ram_data`/`ram_write_addr` hold 0.
- When not in READ: `ram_read_addr` holds 0.

## Timing
- Reset value of every output is 0: `busy`, `done`, `pass`, `err_count`, `first_err_addr`, `ram_data`, both addresses, `ram_we`. The state returns to IDLE.
- Reset asserted mid-run aborts immediately. RAM contents are left partially written, which is acceptable. The next `start` runs a full test.
- Cycle numbering: `start` is accepted at edge 0.
  - WRITE occupies cycles 1..N.
  - READ occupies cycles N+1..2N.
  - DRAIN is cycle 2N+1.
  - `done`/`pass` are valid from cycle 2N+2. For N = 8 this is cycle 18.
- `busy` = 1 exactly in cycles 1..2N+1.
- Read latency: the address is issued in cycle k and the data is compared at the end of cycle k+1.
- The first read (addr 0, cycle N+1) follows the last write (cycle N). The RAM has committed that write at the edge ending cycle N, so the read sees it.
- `start` held high continuously: one run is executed, then a new run begins the cycle after DONE is entered.

## Configuration
- `MEM_BIST_INVERT_PASS_EN` undefined: single pass as described above. Busy lasts 2N+1 cycles.
- `MEM_BIST_INVERT_PASS_EN` defined: adds states WRITE_INV and READ_INV after READ.
  - Sequence: WRITE, READ, WRITE_INV (`ram_data` = ~pat(a)), READ_INV (expected ~pat(a)), DRAIN, DONE.
  - The compare for READ's last address overlaps the first WRITE_INV cycle.
  - Busy lasts 4N+1 cycles. `done` is valid from cycle 4N+2 (34 for N = 8).
  - `err_count` accumulates across both passes. `first_err_addr` reports the earliest mismatch in time.

## Test plan
- Ideal RAM model, N = 8, `seed` = 8'h00, pulse `start` -> writes 00..07 to addresses 0..7; `busy` in cycles 1..17; `done` = 1, `pass` = 1, `err_count` = 0 at cycle 18.
- RAM model with bit 2 stuck at 0 at address 5, `seed` = 8'h04 (pat(5) = 8'h09, no bit-2 hit) -> `pass` = 1. Rerun with `seed` = 8'h00 (pat(5) = 8'h05) -> `err_count` = 1, `first_err_addr` = 5, `pass` = 0.
- `seed` = 8'hFC -> write data FC, FD, FE, FF, 00, 01, 02, 03 (wrap-around); `pass` = 1.
- Assert `rst` in cycle 11 (mid-READ) -> all outputs 0 asynchronously and the state is IDLE. A later `start` completes with `pass` = 1 and `done` 18 cycles after acceptance.
- `start` re-pulsed in cycles 3 and 12 -> ignored; the run ends at cycle 18 unchanged. A `start` in DONE clears `done` and `err_count` and restarts.
- With `MEM_BIST_INVERT_PASS_EN`, `seed` = 8'h00 -> second write pass data FF, FE, ..., F8; `done` at cycle 34; `pass` = 1.

Source files
------------

// File: rtl/mem_bist.sv
// mem_bist -- built-in self-test master for a single-clock dual-port RAM
// (one write port, one registered read port).
//
// On an accepted start the block fills every RAM address with
// pat(a) = seed + a, sweeps the read port, and compares each returned word
// against the expected pattern. The result is reported as pass, a saturating
// error count and the address of the first failing compare.
//
// Optional feature macro: MEM_BIST_INVERT_PASS_EN
//   When defined, a second write/read pass follows using ~pat(a). The error
//   count accumulates across both passes.
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst             asynchronous active-high reset
//   start           begin a run (only honoured in IDLE or DONE)
//   seed            pattern seed, captured on accepted start
//   busy            high while a run is in progress
//   done            level, high in DONE until the next accepted start
//   pass            high in DONE when no mismatch was seen
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatch (0 if none)
//   ram_data        RAM write data
//   ram_write_addr  RAM write address
//   ram_read_addr   RAM read address
//   ram_we          RAM write enable
//   ram_q           RAM read data, valid the cycle after ram_read_addr
module mem_bist #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   seed,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [ADDR_WIDTH+1:0]   err_count,
   output logic [ADDR_WIDTH-1:0]   first_err_addr,
   output logic [DATA_WIDTH-1:0]   ram_data,
   output logic [ADDR_WIDTH-1:0]   ram_write_addr,
   output logic [ADDR_WIDTH-1:0]   ram_read_addr,
   output logic                    ram_we,
   input  logic [DATA_WIDTH-1:0]   ram_q
);

   localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_WRITE_INV, S_READ_INV, S_DRAIN, S_DONE
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   seed_r;
   logic                    cmp_v;
   logic                    cmp_inv;
   logic [ADDR_WIDTH-1:0]   cmp_a;
   logic                    first_err_seen;
   logic [DATA_WIDTH-1:0]   cmp_exp;
   logic                    mismatch;
   logic [ADDR_WIDTH+1:0]   err_next;

   // Expected word for address a; the address is resized to the word width
   // so the sum wraps modulo 2**DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] exp_word(
      input logic [DATA_WIDTH-1:0] s,
      input logic [ADDR_WIDTH-1:0] a,
      input logic                  inv
   );
      logic [DATA_WIDTH-1:0] w;
      w = s + DATA_WIDTH'(a);
      return inv ? ~w : w;
   endfunction

   function automatic logic [ADDR_WIDTH+1:0] sat_inc(input logic [ADDR_WIDTH+1:0] v);
      return (v == {(ADDR_WIDTH+2){1'b1}}) ? v : v + 1'b1;
   endfunction

   assign cmp_exp  = exp_word(seed_r, cmp_a, cmp_inv);
   assign mismatch = cmp_v && (ram_q != cmp_exp);
   assign err_next = mismatch ? sat_inc(err_count) : err_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         seed_r         <= '0;
         cmp_v          <= 1'b0;
         cmp_inv        <= 1'b0;
         cmp_a          <= '0;
         first_err_seen <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         ram_data       <= '0;
         ram_write_addr <= '0;
         ram_read_addr  <= '0;
         ram_we         <= 1'b0;
      end else begin
         // compare stage: ram_q now holds the word for the address issued last cycle
         cmp_v     <= (state == S_READ) || (state == S_READ_INV);
         cmp_inv   <= (state == S_READ_INV);
         cmp_a     <= ram_read_addr;
         err_count <= err_next;
         if (mismatch && !first_err_seen) begin
            first_err_seen <= 1'b1;
            first_err_addr <= cmp_a;
         end

         // issue stage: sequence the RAM port signals
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_WRITE;
                  seed_r         <= seed;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  first_err_seen <= 1'b0;
                  ram_we         <= 1'b1;
                  ram_write_addr <= '0;
                  ram_data       <= seed;
               end
            end
            S_WRITE, S_WRITE_INV: begin
               if (ram_write_addr == LAST) begin
                  ram_we         <= 1'b0;
                  ram_write_addr <= '0;
                  ram_data       <= '0;
                  state          <= (state == S_WRITE_INV) ? S_READ_INV : S_READ;
               end else begin
                  ram_write_addr <= ram_write_addr + 1'b1;
                  ram_data       <= exp_word(seed_r, ram_write_addr + 1'b1,
                                             state == S_WRITE_INV);
               end
            end
            S_READ: begin
               if (ram_read_addr == LAST) begin
                  ram_read_addr <= '0;
`ifdef MEM_BIST_INVERT_PASS_EN
                  // the compare of the last read overlaps this first inverted write
                  state          <= S_WRITE_INV;
                  ram_we         <= 1'b1;
                  ram_write_addr <= '0;
                  ram_data       <= exp_word(seed_r, '0, 1'b1);
`else
                  state <= S_DRAIN;
`endif
               end else begin
                  ram_read_addr <= ram_read_addr + 1'b1;
               end
            end
            S_READ_INV: begin
               if (ram_read_addr == LAST) begin
                  ram_read_addr <= '0;
                  state         <= S_DRAIN;
               end else begin
                  ram_read_addr <= ram_read_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               // err_next already includes the final compare
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_next == '0);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
module tb_mem_bist;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int N  = 8;
   localparam int EW = AW + 2;
`ifdef MEM_BIST_INVERT_PASS_EN
   localparam int P = 2;
`else
   localparam int P = 1;
`endif
   localparam int DONE_CYC = 2 * N * P + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] seed;
   logic          busy, done, pass, ram_we;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_err_addr, ram_write_addr, ram_read_addr;
   logic [DW-1:0] ram_data, ram_q;

   mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .ram_data(ram_data),
      .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
      .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // RAM with optional stuck-at-0 fault on selected bits of one address
   logic [DW-1:0] mem [N];
   logic          f_en;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_mask;
   always @(posedge clk) begin
      if (ram_we) mem[ram_write_addr] <= ram_data;
      ram_q <= (f_en && ram_read_addr == f_addr) ? (mem[ram_read_addr] & ~f_mask)
                                                 : mem[ram_read_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk every pass and address, apply the fault, and tally.
   task automatic model(input logic [7:0] s, input bit en, input logic [2:0] fa,
                        input logic [7:0] fm, output int e, output int first);
      bit found = 0;
      e = 0;
      first = 0;
      for (int p = 0; p < P; p++) begin
         for (int a = 0; a < N; a++) begin
            logic [7:0] w, got;
            w   = s + 8'(a);
            if (p == 1) w = ~w;
            got = (en && a == int'(fa)) ? (w & ~fm) : w;
            if (got != w) begin
               if (!found) begin first = a; found = 1; end
               e = (e == 31) ? 31 : e + 1;
            end
         end
      end
   endtask

   // mode 0: single start pulse; 1: extra pulses in cycles 3 and 12; 2: start held
   task automatic run(input logic [7:0] s, input int mode, output int done_cyc,
                      output bit busy_ok, output bit wr_ok, output logic [EW-1:0] err_c1);
      int idx = 0;
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      @(posedge clk); #1;
      if (mode != 2) start = 1'b0;
      done_cyc = -1;
      busy_ok  = 1;
      wr_ok    = 1;
      err_c1   = err_count;
      for (int c = 1; c <= 200; c++) begin
         if (done) begin
            done_cyc = c;
            if (busy !== 1'b0) busy_ok = 0;
            break;
         end
         if (busy !== (c <= DONE_CYC - 1)) busy_ok = 0;
         if (ram_we) begin
            logic [7:0] w;
            w = s + 8'(idx % N);
            if (idx >= N) w = ~w;
            if (idx >= N * P || ram_write_addr !== AW'(idx % N) || ram_data !== w) wr_ok = 0;
            idx++;
         end
         if (mode == 1) start = (c == 3 || c == 12);
         @(posedge clk); #1;
      end
      if (idx != N * P) wr_ok = 0;
      if (mode == 1) start = 1'b0;
   endtask

   typedef struct {
      logic [7:0] s;
      bit         fen;
      logic [2:0] fa;
      logic [7:0] fm;
      int         e;
      int         first;
      bit         ps;
   } vec_t;

   vec_t vt [6];

   initial begin
      int         dc, e, first;
      bit         bok, wok;
      logic [EW-1:0] ec1;

      vt[0] = '{8'h00, 1'b0, 3'd0, 8'h00, 0, 0, 1'b1};
      vt[3] = '{8'hFC, 1'b0, 3'd0, 8'h00, 0, 0, 1'b1};
      vt[5] = '{8'h00, 1'b1, 3'd7, 8'h01, 1, 7, 1'b0};
      vt[2] = '{8'h00, 1'b1, 3'd5, 8'h04, 1, 5, 1'b0};
`ifdef MEM_BIST_INVERT_PASS_EN
      vt[1] = '{8'h04, 1'b1, 3'd5, 8'h04, 1, 5, 1'b0};
      vt[4] = '{8'h00, 1'b1, 3'd3, 8'hFF, 2, 3, 1'b0};
`else
      vt[1] = '{8'h04, 1'b1, 3'd5, 8'h04, 0, 0, 1'b1};
      vt[4] = '{8'h00, 1'b1, 3'd3, 8'hFF, 1, 3, 1'b0};
`endif

      rst = 1'b1; start = 1'b0; seed = '0;
      f_en = 1'b0; f_addr = '0; f_mask = '0;
      #12;
      chk("reset_outputs", {busy, done, pass, err_count, first_err_addr, ram_data,
                            ram_write_addr, ram_read_addr, ram_we}, 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         f_en = vt[i].fen; f_addr = vt[i].fa; f_mask = vt[i].fm;
         run(vt[i].s, 0, dc, bok, wok, ec1);
         chk($sformatf("vec%0d_done_cycle", i), dc, DONE_CYC);
         chk($sformatf("vec%0d_busy", i), bok, 1);
         chk($sformatf("vec%0d_writes", i), wok, 1);
         chk($sformatf("vec%0d_err_cleared", i), ec1, 0);
         chk($sformatf("vec%0d_err_count", i), err_count, vt[i].e);
         chk($sformatf("vec%0d_first_err", i), first_err_addr, vt[i].first);
         chk($sformatf("vec%0d_pass", i), pass, vt[i].ps);
      end

      // extra start pulses during the run are ignored
      f_en = 1'b0;
      run(8'h5A, 1, dc, bok, wok, ec1);
      chk("repulse_done_cycle", dc, DONE_CYC);
      chk("repulse_writes", wok, 1);
      chk("repulse_pass", {pass, err_count}, {1'b1, 5'd0});

      // start held high: a new run begins the cycle after DONE
      run(8'h33, 2, dc, bok, wok, ec1);
      chk("hold_done_cycle", dc, DONE_CYC);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_restart", {busy, done, ram_we}, 3'b101);
      dc = -1;
      for (int c = 1; c <= 200; c++) begin
         if (done) begin dc = c; break; end
         @(posedge clk); #1;
      end
      chk("hold_second_done", dc, DONE_CYC);
      chk("hold_second_pass", pass, 1);

      // asynchronous reset in cycle 11, mid-READ
      @(negedge clk); seed = 8'h00; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrun_reset_outputs", {busy, done, pass, err_count, first_err_addr, ram_data,
                                   ram_write_addr, ram_read_addr, ram_we}, 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", {busy, ram_we, done}, 3'b000);
      run(8'h00, 0, dc, bok, wok, ec1);
      chk("after_rst_done_cycle", dc, DONE_CYC);
      chk("after_rst_writes", wok, 1);
      chk("after_rst_pass", pass, 1);

      // randomized runs against the reference model
      for (int r = 0; r < 20; r++) begin
         logic [7:0] s;
         s      = 8'($urandom);
         f_en   = 1'($urandom_range(0, 1));
         f_addr = 3'($urandom_range(0, 7));
         f_mask = ($urandom_range(0, 1) != 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
         model(s, f_en, f_addr, f_mask, e, first);
         run(s, 0, dc, bok, wok, ec1);
         chk($sformatf("rnd%0d_done_cycle", r), dc, DONE_CYC);
         chk($sformatf("rnd%0d_busy", r), bok, 1);
         chk($sformatf("rnd%0d_writes", r), wok, 1);
         chk($sformatf("rnd%0d_err_count", r), err_count, e);
         chk($sformatf("rnd%0d_first_err", r), first_err_addr, first);
         chk($sformatf("rnd%0d_pass", r), pass, e == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
